// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices in a WIDTH-bit operand; 0 flags an illegal CHUNK.
    function automatic int nchunk(input int width, input int chunk);
        if (chunk < 1) begin
            return 0;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational adder slice with carry in and carry out.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s      = w_full[CHUNK-1:0];
    assign cout   = w_full[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per BUSY cycle, valid/ready on both sides.
// Optional subtract input enabled by defining SEQ_CHUNK_ADDER_SUB_EN.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("seq_chunk_adder: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_last;
    logic [KW-1:0]    r_k;
    logic             r_cy;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin0;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK-1:0] w_cs;
    logic             w_cout;

    // Subtraction is folded in at capture: a - b == a + ~b + 1, so the
    // chunk loop itself never needs to know which operation is running.
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    assign w_b_eff = sub ? ~b : b;
    assign w_cin0  = sub;
`else
    assign w_b_eff = b;
    assign w_cin0  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_k == KW'(NCHUNK - 1));

    assign w_ca = r_a[r_k*CHUNK +: CHUNK];
    assign w_cb = r_b[r_k*CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .a   (w_ca),
        .b   (w_cb),
        .cin (r_cy),
        .s   (w_cs),
        .cout(w_cout)
    );

    // Operand registers carry no reset; they are only read after a capture.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= w_b_eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= '0;
            r_cy    <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_k  <= '0;
            r_cy <= w_cin0;
        end else if (r_state == BUSY) begin
            r_sum[r_k*CHUNK +: CHUNK] <= w_cs;
            r_cy                      <= w_cout;
            r_k                       <= r_k + KW'(1);
            if (w_last) begin
                r_carry <= w_cout;
            end
        end
    end

    assign sum   = r_sum;
    assign carry = r_carry;

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits added per clock cycle.
REQ-003 SHALL have clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have in_valid, input, 1: operands present.
REQ-006 SHALL have in_ready, output, 1: block can accept operands.
REQ-007 SHALL have a, input, WIDTH: first operand.
REQ-008 SHALL have b, input, WIDTH: second operand.
REQ-009 SHALL have out_valid, output, 1: result present.
REQ-010 SHALL have out_ready, input, 1: consumer takes result.
REQ-011 SHALL have sum, output, WIDTH: registered result.
REQ-012 SHALL have carry, output, 1: registered carry-out of bit WIDTH-1.

Function
REQ-013 SHALL use NCHUNK = WIDTH/CHUNK; WIDTH not a multiple of CHUNK, or CHUNK < 1, SHALL be an elaboration error.
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL hold in_ready = 1 only in IDLE.
REQ-016 Accept: in_valid && in_ready at an edge SHALL capture a and b, clear the internal carry and chunk index, and go IDLE->BUSY.
REQ-017 Each BUSY cycle SHALL add chunk k of the captured operands plus the carry register, write chunk k of sum, update the carry register, and increment k.
REQ-018 After chunk NCHUNK-1 is written, SHALL go BUSY->DONE with out_valid = 1; latency from accept edge to out_valid high SHALL be exactly NCHUNK cycles.
REQ-019 In DONE, out_valid, sum and carry SHALL hold stable until out_ready = 1; at that edge SHALL go DONE->IDLE.
REQ-020 in_valid in BUSY or DONE SHALL be ignored; operands SHALL not be captured.
REQ-021 a and b changing after accept SHALL not affect the result.
REQ-022 sum and carry SHALL equal {carry,sum} = a + b, modulo 2^(WIDTH+1).
REQ-023 With CHUNK = WIDTH, result SHALL be available after 1 cycle in BUSY.

Reset
REQ-024 rst high SHALL immediately force IDLE, in_ready = 1, out_valid = 0, sum = 0, carry = 0, and clear the internal carry and index.
REQ-025 rst during BUSY or DONE SHALL abort the operation with no output produced.

Configuration
REQ-026 Macro SEQ_CHUNK_ADDER_SUB_EN defined: SHALL add input sub (1 bit), captured with the operands; sub = 1 SHALL compute a + ~b + 1, with carry = 1 meaning no borrow.
REQ-027 Macro undefined: SHALL have no sub port and addition only.

Structure
REQ-028 SHALL place the state enum and the NCHUNK derivation function in package seq_chunk_adder_pkg.
REQ-029 SHALL use one combinational sub-module chunk_adder: CHUNK-bit add with cin and cout.

Verification
REQ-030 WIDTH=32, CHUNK=8: a=0xFFFF_FFFF, b=0x1 accepted -> out_valid 4 cycles later, sum=0x0000_0000, carry=1.
REQ-031 WIDTH=32, CHUNK=8: a=0x1234_5678, b=0x1111_1111 -> sum=0x2345_6789, carry=0; out_ready held 0 for 5 cycles -> outputs stable and in_ready=0 throughout.
REQ-032 rst pulsed 2 cycles after accept -> out_valid=0 and in_ready=1 immediately; the next transaction a=3, b=4 -> sum=7.
REQ-033 in_valid held high in BUSY with different operands -> ignored; result matches the first operands.
REQ-034 SEQ_CHUNK_ADDER_SUB_EN, WIDTH=8, CHUNK=4: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0 after 2 cycles.
REQ-035 WIDTH=8, CHUNK=8: a=0x80, b=0x80 -> out_valid after 1 cycle, sum=0x00, carry=1.
